// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout, transmit FSM states and the baud divider calculation.
`timescale 1ns/1ps
package uart_pkg;

  // Register offsets within the two-byte I/O window.
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS bit positions.
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       overflow;
    logic       busy;
    logic       empty;
    logic       full;
  } status_t;

  // Clocks per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO: registered storage, combinational head, extra pointer MSB
// to tell full from empty. A push while full is accepted only alongside a pop.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone say what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS register decode on the CPU
// data bus, a TX byte FIFO, and the baud/shift state machine driving tx.
`timescale 1ns/1ps
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_HZ     = 25_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE       = 16'h1800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        read,
  output logic        hit,
  output logic [7:0]  rdata,
  output logic        tx,
  output logic        irq
);

  localparam int             DIV         = baud_div(CLK_HZ, BAUD);
  localparam int             CW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  BAUD_RELOAD = CW'(DIV - 1);

  // ---------------------------------------------------------------- decode
  logic [15:0] offset;
  logic        sel_data;
  logic        sel_status;

  assign offset     = address - BASE;
  assign hit        = (offset[15:1] == 15'd0);
  assign sel_data   = hit && (offset[0] == REG_DATA);
  assign sel_status = hit && (offset[0] == REG_STATUS);

  // ---------------------------------------------------------------- fifo
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  assign fifo_push = we && sel_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------- tx fsm
  tx_state_t      state, state_n;
  logic [CW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_cnt, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx_q, tx_n;
  logic           irq_q;
  logic           overflow_flag;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    tx_n     = tx_q;
    fifo_pop = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_head;
          tx_n     = 1'b0;
          baud_n   = BAUD_RELOAD;
          state_n  = START;
        end
      end

      START: begin
        if (baud_cnt == '0) begin
          state_n = DATA;
          tx_n    = shift[0];
          bit_n   = '0;
          baud_n  = BAUD_RELOAD;
        end else begin
          baud_n = baud_cnt - CW'(1);
        end
      end

      DATA: begin
        if (baud_cnt == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt - CW'(1);
        end
      end

      STOP: begin
        if (baud_cnt == '0) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_head;
            tx_n     = 1'b0;
            baud_n   = BAUD_RELOAD;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - CW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- status
  logic ovf_set;
  logic ovf_clr;

  assign ovf_set = fifo_push && fifo_full && !fifo_pop;
  assign ovf_clr = read && sel_status;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      tx_q          <= 1'b1;
      irq_q         <= 1'b1;
      overflow_flag <= 1'b0;
    end else begin
      state         <= state_n;
      baud_cnt      <= baud_n;
      bit_cnt       <= bit_n;
      shift         <= shift_n;
      tx_q          <= tx_n;
      irq_q         <= (state == IDLE) && fifo_empty;
      // A new overflow in the same cycle as a STATUS read wins over the clear.
      overflow_flag <= ovf_set || (overflow_flag && !ovf_clr);
    end
  end

  status_t status;

  always_comb begin
    status          = '0;
    status.overflow = overflow_flag;
    status.busy     = (state != IDLE);
    status.empty    = fifo_empty;
    status.full     = fifo_full;
  end

  assign rdata = sel_status ? status : 8'h00;
  assign tx    = tx_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: decode table, exact frame timing,
// FIFO overflow/pop corners, mid-frame reset and randomized traffic.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam int          DIV  = 217;
  localparam logic [15:0] BASE = 16'h1800;
  localparam logic [15:0] STAT = 16'h1801;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic        read;
  logic        hit;
  logic [7:0]  rdata;
  logic        tx;
  logic        irq;

  int n_cmp;
  int n_bad;
  int cyc;
  int frame_err;
  int last_start;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];

  uart_tx_mmio #(
    .CLK_HZ     (25_000_000),
    .BAUD       (115_200),
    .FIFO_DEPTH (16),
    .BASE       (16'h1800)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .wdata   (wdata),
    .we      (we),
    .read    (read),
    .hit     (hit),
    .rdata   (rdata),
    .tx      (tx),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Line receiver: samples mid-bit and queues every decoded byte with its start edge.
  initial begin : line_monitor
    logic [7:0] b;
    int         t;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        t          = cyc;
        last_start = cyc;
        repeat (DIV / 2) @(negedge clock);
        if (tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clock);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clock);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(b);
        rx_t.push_back(t);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    we      = 1'b1;
    tick();
    we      = 1'b0;
    address = 16'h0000;
  endtask

  task automatic peek(output logic [7:0] s);
    address = STAT;
    #1;
    s = rdata;
  endtask

  task automatic wait_idle(input int budget, output int t_done, output bit ok);
    logic [7:0] s;
    ok     = 1'b0;
    t_done = cyc;
    for (int i = 0; i < budget; i++) begin
      peek(s);
      if (s[2] == 1'b0) begin
        ok     = 1'b1;
        t_done = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic compare_rx(input string tag);
    int n;
    n = exp_q.size();
    check({tag, " frame count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) check($sformatf("%s byte%0d", tag, i), rx_q[i], exp_q[i]);
    end
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic        rd;
    logic [7:0]  wd;
    logic        exp_hit;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] s;
  logic [7:0] d;
  int         t_s;
  int         t_a;
  int         t_done;
  bit         ok;
  int         model_cnt;
  int         bad_cnt[10];
  int         busy_bad;
  int         low_cnt;
  int         gap;

  initial begin : main
    reset   = 1'b1;
    address = 16'h0000;
    wdata   = 8'h00;
    we      = 1'b0;
    read    = 1'b0;

    vecs[0]  = '{16'h1800, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{16'h1801, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02};
    vecs[2]  = '{16'h1802, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{16'h17FF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{16'h1801, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h02};
    vecs[5]  = '{16'h1802, 1'b1, 1'b0, 8'hAA, 1'b0, 8'h00};
    vecs[6]  = '{16'h0000, 1'b1, 1'b0, 8'h33, 1'b0, 8'h00};
    vecs[7]  = '{16'h1801, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02};
    vecs[8]  = '{16'hFFFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{16'h1800, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[10] = '{16'h1801, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset tx", tx, 1'b1);
    check("reset irq", irq, 1'b1);
    peek(s);
    check("reset status", s, 8'h02);
    tick();

    // Decode table: window hits, STATUS mux, ignored writes
    for (int i = 0; i < 11; i++) begin
      address = vecs[i].addr;
      we      = vecs[i].wr;
      read    = vecs[i].rd;
      wdata   = vecs[i].wd;
      #1;
      check($sformatf("vec%0d hit", i), hit, vecs[i].exp_hit);
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      tick();
      we   = 1'b0;
      read = 1'b0;
    end
    check("no frame after ignored writes", tx, 1'b1);

    // Single frame 0x55: cycle-exact waveform
    bus_write(BASE, 8'h55);
    exp_q.push_back(8'h55);
    check("tx high on push edge", tx, 1'b1);
    tick();
    address = STAT;
    #1;
    busy_bad = 0;
    for (int i = 0; i < 10; i++) bad_cnt[i] = 0;
    for (int c = 0; c < 10 * DIV; c++) begin
      if (tx !== frame_bit(8'h55, c / DIV)) bad_cnt[c / DIV]++;
      if (rdata[2] !== 1'b1) busy_bad++;
      tick();
    end
    for (int i = 0; i < 10; i++) check($sformatf("frame55 bit%0d wrong cycles", i), bad_cnt[i], 0);
    check("frame55 busy drop cycles", busy_bad, 0);
    peek(s);
    check("frame55 status after stop", s, 8'h02);
    check("frame55 irq not yet", irq, 1'b0);
    tick();
    check("frame55 irq after", irq, 1'b1);
    check("frame55 tx idle", tx, 1'b1);
    compare_rx("frame55");

    // Back-to-back frames 0x41, 0x42
    bus_write(BASE, 8'h41);
    t_s = cyc + 1;
    bus_write(BASE, 8'h42);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    wait_idle(3 * 10 * DIV, t_done, ok);
    check("b2b finished", ok, 1'b1);
    check("b2b total cycles", t_done - t_s, 20 * DIV);
    check("b2b first start edge", (rx_t.size() > 0) ? rx_t[0] : -1, t_s);
    check("b2b frame spacing", (rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1, 10 * DIV);
    compare_rx("b2b");
    tick();

    // Overflow: one byte in the shifter, then 17 writes with no pop
    bus_write(BASE, 8'hA0);
    exp_q.push_back(8'hA0);
    t_a       = cyc + 1;
    model_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      d = 8'h10 + 8'(i);
      bus_write(BASE, d);
      if (model_cnt < 16) begin
        exp_q.push_back(d);
        model_cnt++;
      end
    end
    peek(s);
    check("ovf status full+busy+ovf", s, 8'h0D);
    check("ovf first start edge", last_start, t_a);
    address = STAT;
    read    = 1'b1;
    #1;
    check("ovf read shows flag", rdata, 8'h0D);
    tick();
    read = 1'b0;
    peek(s);
    check("ovf cleared by read", s, 8'h05);

    // Write while full on the exact edge the FSM pops the next byte
    while (cyc < t_a + 10 * DIV - 1) tick();
    bus_write(BASE, 8'hEE);
    exp_q.push_back(8'hEE);
    peek(s);
    check("full+pop write accepted", s, 8'h05);
    tick();
    wait_idle(20 * 10 * DIV, t_done, ok);
    check("ovf drain finished", ok, 1'b1);
    check("ovf drain frame spacing", (rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1, 10 * DIV);
    compare_rx("ovf drain");
    tick();

    // Reset during data bit 4 with three bytes queued
    bus_write(BASE, 8'h00);
    t_s = cyc + 1;
    for (int i = 0; i < 3; i++) bus_write(BASE, 8'h00);
    while (cyc < t_s + 5 * DIV + 50) tick();
    check("line low in data bit 4", tx, 1'b0);
    reset = 1'b1;
    tick();
    check("mid-frame reset tx", tx, 1'b1);
    check("mid-frame reset irq", irq, 1'b1);
    peek(s);
    check("mid-frame reset status", s, 8'h02);
    reset   = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 3 * 10 * DIV; c++) begin
      tick();
      if (tx !== 1'b1) low_cnt++;
    end
    check("no frames after reset", low_cnt, 0);
    peek(s);
    check("status after reset quiet", s, 8'h02);
    rx_q.delete();
    rx_t.delete();

    // Randomized traffic against the byte-queue model
    for (int k = 0; k < 4; k++) begin
      gap = $urandom_range(0, 800);
      repeat (gap) tick();
      if ($urandom_range(0, 2) == 0) bus_write(STAT, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        address = STAT;
        read    = 1'b1;
        #1;
        check($sformatf("rand%0d overflow clear", k), rdata[3], 1'b0);
        tick();
        read = 1'b0;
      end
      d = 8'($urandom);
      bus_write(BASE, d);
      exp_q.push_back(d);
    end
    tick();
    wait_idle(6 * 10 * DIV, t_done, ok);
    check("random drain finished", ok, 1'b1);
    compare_rx("random");
    peek(s);
    check("final status", s, 8'h02);
    tick();
    check("final irq", irq, 1'b1);
    check("framing errors", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
